// File: rtl/sram_delay_line.sv
// Circular-buffer delay line: each enabled write stores a word and advances the
// pointer; read_data always shows the oldest entry (the one about to be overwritten).
module sram_delay_line #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_en,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  generate
    if (DEPTH < 2 || DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
      $error("sram_delay_line: DEPTH must be in 2..2**ADDR_WIDTH");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] ptr;
  logic [IW-1:0]         idx;

  // ptr never reaches DEPTH, so its low IW bits address the array exactly
  assign idx       = ptr[IW-1:0];
  assign read_data = mem[idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (write_en) begin
      mem[idx] <= write_data;
      ptr      <= (ptr == ADDR_WIDTH'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_delay_line.sv
// Directed bench for sram_delay_line at DEPTH=2 and DEPTH=4; stimulus pushes
// expected words into a queue, a monitor pops and compares after each edge.
module tb_sram_delay_line;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          we2 = 1'b0, we4 = 1'b0;
  logic [DW-1:0] wd2 = '0, wd4 = '0;
  logic [DW-1:0] rd2, rd4;

  sram_delay_line #(.ADDR_WIDTH(8), .DATA_WIDTH(DW), .DEPTH(2)) dut2 (
    .clk(clk), .rst(rst), .write_en(we2), .write_data(wd2), .read_data(rd2));
  sram_delay_line #(.ADDR_WIDTH(8), .DATA_WIDTH(DW), .DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .write_en(we4), .write_data(wd4), .read_data(rd4));

  always #5 clk = ~clk;

  typedef struct {
    bit            sel4;
    logic [DW-1:0] exp;
    int            id;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic cmp(input string name, input int id, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s #%0d: got %h want %h", name, id, act, exp);
    end
  endtask

  // monitor: one queued expectation is retired per clock edge
  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.sel4) cmp("rd_d4", e.id, rd4, e.exp);
      else        cmp("rd_d2", e.id, rd2, e.exp);
    end
  end

  int step_id = 0;

  // drive one cycle on the selected DUT; exp is read_data after the coming edge
  task automatic step(input bit sel4, input bit we, input logic [DW-1:0] d,
                      input logic [DW-1:0] exp);
    exp_t e;
    @(negedge clk);
    we2 = 1'b0; we4 = 1'b0;
    if (sel4) begin we4 = we; wd4 = d; end
    else      begin we2 = we; wd2 = d; end
    e.sel4 = sel4; e.exp = exp; e.id = step_id++;
    q.push_back(e);
  endtask

  // reset asserted between edges; outputs must clear without waiting for clk
  task automatic pulse_rst(input string name);
    @(negedge clk);
    we2 = 1'b0; we4 = 1'b0;
    #2 rst = 1'b1;
    #1;
    cmp({name, "_d2"}, 0, rd2, '0);
    cmp({name, "_d4"}, 0, rd4, '0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    cmp({name, "_rel_d2"}, 0, rd2, '0);
    cmp({name, "_rel_d4"}, 0, rd4, '0);
  endtask

  initial begin
    #1;
    cmp("por_d2", 0, rd2, '0);
    cmp("por_d4", 0, rd4, '0);
    @(negedge clk);
    rst = 1'b0;

    // reset clears live history; hold afterwards stays 0
    step(0, 1, 32'hA5A5_0001, 32'h0);
    step(0, 1, 32'hA5A5_0002, 32'hA5A5_0001);
    pulse_rst("rst_clear");
    step(0, 0, 32'h1234_5678, 32'h0);
    step(0, 0, 32'h1234_5678, 32'h0);

    // DEPTH=2 continuous writes
    pulse_rst("rst_a");
    step(0, 1, 32'd1, 32'd0);
    step(0, 1, 32'd2, 32'd1);
    step(0, 1, 32'd3, 32'd2);
    step(0, 1, 32'd4, 32'd3);
    step(0, 1, 32'd5, 32'd4);

    // DEPTH=4 continuous writes across the 3->0 wrap
    pulse_rst("rst_b");
    step(1, 1, 32'd10, 32'd0);
    step(1, 1, 32'd20, 32'd0);
    step(1, 1, 32'd30, 32'd0);
    step(1, 1, 32'd40, 32'd10);
    step(1, 1, 32'd50, 32'd20);
    step(1, 1, 32'd60, 32'd30);

    // hold cycles stretch the delay
    pulse_rst("rst_c");
    step(0, 1, 32'd7, 32'd0);
    step(0, 1, 32'd8, 32'd7);
    step(0, 0, 32'hDEAD_BEEF, 32'd7);
    step(0, 0, 32'hDEAD_BEEF, 32'd7);
    step(0, 0, 32'hDEAD_BEEF, 32'd7);
    step(0, 1, 32'd9, 32'd8);

    // bit-exact extreme patterns
    pulse_rst("rst_d");
    step(0, 1, 32'h8000_0000, 32'h0);
    step(0, 1, 32'hFFFF_FFFF, 32'h8000_0000);
    step(0, 1, 32'h0000_0000, 32'hFFFF_FFFF);

    // mid-run reset on DEPTH=4: nothing from before the reset may reappear
    pulse_rst("rst_e");
    step(1, 1, 32'd101, 32'd0);
    step(1, 1, 32'd102, 32'd0);
    step(1, 1, 32'd103, 32'd0);
    step(1, 1, 32'd104, 32'd101);
    step(1, 1, 32'd105, 32'd102);
    step(1, 1, 32'd106, 32'd103);
    pulse_rst("rst_mid");
    step(1, 1, 32'd1, 32'd0);
    step(1, 1, 32'd2, 32'd0);
    step(1, 1, 32'd3, 32'd0);
    step(1, 1, 32'd4, 32'd1);
    step(1, 1, 32'd5, 32'd2);

    @(negedge clk);
    we2 = 1'b0; we4 = 1'b0;
    @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_delay_line.md
Name: sram_delay_line

Overview:
- Parameterised circular-buffer memory used as a fixed-length sample delay line.
- Each enabled clock writes one word and advances an internal address pointer.
- The read port always presents the word written DEPTH accepted writes earlier.
- Sits inside the interpolation filter's comb stages, which supply the x[n-M] history term.

Parameters:
- ADDR_WIDTH, 8, width of the internal write/read pointer; must satisfy DEPTH <= 2**ADDR_WIDTH.
- DATA_WIDTH, 32, width of each stored word and of the data ports.
- DEPTH, 2, number of stored words (delay length in accepted writes); legal range 2..2**ADDR_WIDTH.

Ports:
- clk, input, 1, single clock; all state updates on its rising edge.
- rst, input, 1, asynchronous active-high reset.
- write_en, input, 1, write/advance enable for the current cycle.
- write_data, input, DATA_WIDTH, word to store.
- read_data, output, DATA_WIDTH, oldest stored word, i.e. the entry at the current pointer.
- Port order is exactly as listed: clk, rst, write_en, write_data, read_data. Parent modules connect positionally.

Behaviour:
- Storage
  - Array mem[0..DEPTH-1] of DATA_WIDTH-bit registers.
  - Pointer ptr is ADDR_WIDTH bits wide.
- Reset
  - rst high asynchronously clears every mem entry to 0 and ptr to 0.
  - read_data = 0 while rst is high and immediately after release.
  - Reset is honoured mid-operation: all history is discarded.
  - The first edge with rst low is a normal cycle.
- Write cycle (rising clk, rst low, write_en = 1)
  - mem[ptr] <= write_data.
  - ptr <= (ptr == DEPTH-1) ? 0 : ptr + 1. Wrap at DEPTH, not at 2**ADDR_WIDTH.
- Hold cycle (write_en = 0): mem and ptr unchanged, read_data stable.
- read_data
  - Combinational decode of mem[ptr]. No combinational path from write_data.
  - After k writes, read_data equals the (k-DEPTH)-th written word, or 0 if k < DEPTH.
  - Delay is exactly DEPTH accepted writes. Hold cycles stretch the delay in clock terms.
- Simultaneous read/write of the same entry:
  - During the write cycle, read_data shows the old contents (read-before-write).
  - On the following cycle it shows the next-oldest entry.
- Data is opaque. No arithmetic, sign handling or saturation; values are stored and returned bit-exact.
- Elaboration checks: DEPTH < 2 or DEPTH > 2**ADDR_WIDTH is an error (report via generate-time $error or equivalent).
- No other outputs or flags.

Test Plan:
- Reset: drive mem non-zero with writes, assert rst asynchronously between edges -> read_data = 0 immediately; after release with write_en = 0, it stays 0.
- DEPTH=2, write_en = 1 every cycle, write_data = 1,2,3,4,5 -> read_data after each edge = 0,1,2,3,4. Before the first edge it is 0.
- DEPTH=4, writes 10,20,30,40,50,60 -> read_data = 0,0,0,10,20,30. Pointer wraps 3->0 with no glitch.
- Hold: DEPTH=2, write 7,8, deassert write_en for 3 cycles -> read_data stays 7; the next write of 9 makes read_data = 8.
- Bit-exactness: DEPTH=2, write 32'h8000_0000 and 32'hFFFF_FFFF -> read back identical patterns after 2 writes each.
- Mid-run reset: DEPTH=4, after 6 writes assert rst, release, write 1,2,3,4,5 -> read_data = 0,0,0,1,2 (no pre-reset data leaks).
